memory_interface_unit: RTL and testbench
========================================

// Module: memory_interface_unit
// PURPOSE
//   Memory port of the microarchitecture datapath; sits beside the register bank, downstream of the ALU.
//   Holds MAR, MDR, PC and MBR, loads them from bus C, and runs rd/wr/fetch cycles against external memory.
//   Completion uses a req/ack handshake. Stalls the control store while a memory cycle is in flight.
//   MDR, PC and MBR feed back into the register bank B-bus sources.
// PARAMETERS
//   DATA_W      32   bus C / memory data width
//   SEL_W       9    width of c_select (one-hot bus C write enables)
//   SEL_MAR     0    c_select bit that loads MAR
//   SEL_MDR     1    c_select bit that loads MDR
//   SEL_PC      2    c_select bit that loads PC
//   TIMEOUT     15   max cycles waiting for mem_ack before abort (>=1)
// PORTS
//   clock        in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-low reset
//   c_select     in   SEL_W   bus C write enables from control store
//   c_data       in   DATA_W  bus C value (ALU/shifter output)
//   mem_op       in   3       {fetch,wr,rd} one-hot request for this microinstruction; 000 = none
//   mar          out  DATA_W  word address register
//   mdr          out  DATA_W  memory data register
//   pc           out  DATA_W  byte address of next opcode byte
//   mbr          out  8       fetched opcode byte
//   stall        out  1       hold control store; high while any cycle is in flight
//   mem_err      out  1       sticky: a cycle timed out; cleared only by reset
//   mem_req      out  1       memory request, held until ack or timeout
//   mem_we       out  1       1 = write cycle (valid with mem_req)
//   mem_byte     out  1       1 = byte fetch cycle
//   mem_addr     out  DATA_W  byte address: {mar[29:0],2'b00} for rd/wr, pc for fetch
//   mem_wdata    out  DATA_W  mdr during write cycles, else 0
//   mem_ack      in   1       memory done; one-cycle pulse, rdata valid same cycle
//   mem_rdata    in   DATA_W  read data; fetch uses [7:0]
// BEHAVIOUR
//   Reset (reset=0, async): mar=mdr=pc=0, mbr=0, stall=0, mem_err=0, mem_req=0, mem_we=0, mem_byte=0, FSM=IDLE.
//   Bus C loads (stall=0 only): on the clock edge, bit SEL_x loads c_data into x. Several bits may be set at once.
//   Issue (stall=0, mem_op!=0): rd/wr/fetch are latched as pending flags. rd and wr together is illegal.
//     If both are set, the op is treated as wr and mem_err is set.
//   Address bypass: a rd/wr issued in the same cycle as a MAR load uses the new c_data value.
//     Likewise, a fetch issued with a PC load uses the new c_data value. A wr issued with an MDR load writes the new value.
//   While stall=1: c_select and mem_op are ignored, and no register is written from bus C.
//   FSM states: IDLE, DATA, FETCH.
//     IDLE  -> DATA if data pending, else FETCH if fetch pending. Data has priority over fetch.
//     DATA  -> mem_req=1, mem_we=wr. On ack: a rd loads mdr<=mem_rdata; a wr writes nothing locally.
//              Then go to FETCH if fetch pending, else IDLE.
//     FETCH -> mem_req=1, mem_byte=1. On ack: mbr<=mem_rdata[7:0]. Then go to IDLE.
//   mem_req rises the cycle after issue. With ack in the same cycle as req, rd-to-MDR latency is 2 cycles.
//   stall is registered. It goes high the cycle after issue and low the cycle after the final ack.
//     Net effect: control resumes with the new MDR/MBR visible.
//   Timeout: a 4-bit wait counter runs while mem_req=1. When it reaches TIMEOUT with no ack:
//     drop mem_req, set mem_err, leave the target register unchanged, and continue as if acked.
//   mem_ack while mem_req=0 is ignored.
//   Reset mid-cycle: everything returns to reset values at once; the in-flight op is lost.
//   No PC auto-increment. PC+1 is computed by the ALU over bus C.
// STRUCTURE
//   Shared package mem_if_pkg: op encodings (MEM_RD=3'b001, MEM_WR=3'b010, MEM_FETCH=3'b100),
//     FSM state enum, default SEL_* bit positions (shared with the register bank).
//   One sub-module: mem_timeout_counter (load/clear/expire; parameter TIMEOUT).
//   FSM, pending flags and MAR/MDR/PC/MBR registers live in the top module.
// TESTING
//   1 Reset: drive reset=0 mid-cycle with mem_req=1 -> all outputs 0 asynchronously, no further req.
//   2 Bus C load + rd: c_select bit0, c_data=0x10, mem_op=rd -> mem_addr=0x40 next cycle.
//     ack with rdata=0xDEADBEEF -> mdr=0xDEADBEEF; stall low the cycle after ack.
//   3 wr with bypass: load MDR=0x12345678 and issue wr in one cycle -> mem_we=1, mem_wdata=0x12345678.
//     mdr unchanged after ack.
//   4 rd+fetch together: pc=5, mar=2 -> data cycle first (addr 0x8), then fetch at addr 5.
//     rdata=0xAB -> mbr=0xAB; stall covers both cycles.
//   5 Timeout: rd with no ack -> mem_req drops after TIMEOUT cycles, mem_err=1, mdr unchanged, stall releases.
//   6 Writes during stall: c_select=MAR with c_data=0xFF while stall=1 -> mar unchanged.

Source files
------------

// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
//   Definitions shared by the memory interface unit and the register bank:
//   - mem_op request encodings (one-hot {fetch, wr, rd})
//   - memory FSM state constants
//   - default bus C select bit positions for MAR/MDR/PC
// ----------------------------------------------------------------------------
package mem_if_pkg;

    // mem_op encodings; several bits may be set in one microinstruction
    localparam logic [2:0] MEM_NONE  = 3'b000;
    localparam logic [2:0] MEM_RD    = 3'b001;
    localparam logic [2:0] MEM_WR    = 3'b010;
    localparam logic [2:0] MEM_FETCH = 3'b100;

    // memory FSM states
    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE  = 2'd0;
    localparam mem_state_t ST_DATA  = 2'd1;
    localparam mem_state_t ST_FETCH = 2'd2;

    // default bus C write-enable bit positions (register bank uses the same)
    localparam int SEL_MAR_DEF = 0;
    localparam int SEL_MDR_DEF = 1;
    localparam int SEL_PC_DEF  = 2;

endpackage : mem_if_pkg

// File: rtl/mem_timeout_counter.sv
// ----------------------------------------------------------------------------
// mem_timeout_counter
//   Counts cycles while a memory request is outstanding and flags expiry when
//   the request has been held for TIMEOUT cycles without completion.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   clear     in   restart the count (current cycle completed or aborted)
//   count_en  in   a request is outstanding this cycle
//   expired   out  this is the TIMEOUT-th cycle of the request (combinational)
// ----------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Count starts at 0 on the first request cycle, so the last allowed
    // cycle is the one where the count equals TIMEOUT-1.
    localparam logic [3:0] LIMIT = 4'(TIMEOUT - 1);

    logic [3:0] count_reg;
    logic [3:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 4'd0;
        end else if (count_en) begin
            count_next = count_reg + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= 4'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = count_en && (count_reg == LIMIT);

endmodule : mem_timeout_counter

// File: rtl/memory_interface_unit.sv
// ----------------------------------------------------------------------------
// memory_interface_unit
//   Memory port of the datapath. Holds MAR, MDR, PC and MBR, loads them from
//   bus C, and runs read / write / opcode-fetch cycles against external memory
//   with a req/ack handshake. The control store is stalled while any cycle is
//   in flight.
// Ports:
//   clock, reset            clock (rising edge), async active-low reset
//   c_select, c_data        bus C write enables and value
//   mem_op                  {fetch,wr,rd} request for this microinstruction
//   mar, mdr, pc, mbr       architectural registers (B-bus sources)
//   stall                   hold control store while a cycle is in flight
//   mem_err                 sticky error: timeout or illegal rd+wr request
//   mem_req/we/byte         memory request, write strobe, byte-fetch flag
//   mem_addr, mem_wdata     byte address and write data
//   mem_ack, mem_rdata      one-cycle completion pulse and read data
// ----------------------------------------------------------------------------
module memory_interface_unit
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 9,
    parameter int SEL_MAR = SEL_MAR_DEF,
    parameter int SEL_MDR = SEL_MDR_DEF,
    parameter int SEL_PC  = SEL_PC_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  c_select,
    input  logic [DATA_W-1:0] c_data,
    input  logic [2:0]        mem_op,
    output logic [DATA_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] pc,
    output logic [7:0]        mbr,
    output logic              stall,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    mem_state_t        state_reg, state_next;
    logic              pend_rd_reg, pend_rd_next;
    logic              pend_wr_reg, pend_wr_next;
    logic              pend_fetch_reg, pend_fetch_next;
    logic              stall_reg;
    logic              err_reg;
    logic [DATA_W-1:0] mar_reg, mdr_reg, pc_reg;
    logic [7:0]        mbr_reg;

    logic rd_in, wr_in, fetch_in;
    logic issue, illegal_op;
    logic ack_valid, expired, done;

    // Bits of c_select beyond MAR/MDR/PC belong to the register bank.
    logic unused_sel_bits;
    assign unused_sel_bits = ^c_select;

    assign rd_in    = |(mem_op & MEM_RD);
    assign wr_in    = |(mem_op & MEM_WR);
    assign fetch_in = |(mem_op & MEM_FETCH);

    // Requests are only accepted while the control store is running.
    assign issue      = !stall_reg && (mem_op != MEM_NONE);
    assign illegal_op = issue && rd_in && wr_in;

    // A request is outstanding in every non-idle state; ack outside a
    // request is ignored.
    assign mem_req   = (state_reg != ST_IDLE);
    assign ack_valid = mem_req && mem_ack;
    assign done      = ack_valid || expired;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (done),
        .count_en (mem_req),
        .expired  (expired)
    );

    // Next-state: issuing goes straight to the first memory state so that
    // mem_req is asserted the cycle after issue. Data cycle beats fetch.
    always_comb begin
        state_next      = state_reg;
        pend_rd_next    = pend_rd_reg;
        pend_wr_next    = pend_wr_reg;
        pend_fetch_next = pend_fetch_reg;
        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    // rd together with wr degrades to a write
                    pend_rd_next    = rd_in && !wr_in;
                    pend_wr_next    = wr_in;
                    pend_fetch_next = fetch_in;
                    state_next      = (rd_in || wr_in) ? ST_DATA : ST_FETCH;
                end
            end
            ST_DATA: begin
                if (done) begin
                    pend_rd_next = 1'b0;
                    pend_wr_next = 1'b0;
                    state_next   = pend_fetch_reg ? ST_FETCH : ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (done) begin
                    pend_fetch_next = 1'b0;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                pend_rd_next    = 1'b0;
                pend_wr_next    = 1'b0;
                pend_fetch_next = 1'b0;
                state_next      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            pend_rd_reg    <= 1'b0;
            pend_wr_reg    <= 1'b0;
            pend_fetch_reg <= 1'b0;
            stall_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_rd_reg    <= pend_rd_next;
            pend_wr_reg    <= pend_wr_next;
            pend_fetch_reg <= pend_fetch_next;
            // Registered stall: rises after issue, falls after final ack.
            stall_reg      <= (state_next != ST_IDLE);
            if (illegal_op || expired) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Bus C loads happen on the issue edge itself, so a cycle issued together
    // with a MAR/MDR/PC load naturally uses the freshly loaded value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mar_reg <= '0;
            mdr_reg <= '0;
            pc_reg  <= '0;
            mbr_reg <= 8'd0;
        end else begin
            if (!stall_reg) begin
                if (c_select[SEL_MAR]) mar_reg <= c_data;
                if (c_select[SEL_MDR]) mdr_reg <= c_data;
                if (c_select[SEL_PC])  pc_reg  <= c_data;
            end
            // Memory results only arrive while stalled, so they never
            // collide with a bus C load.
            if (state_reg == ST_DATA && pend_rd_reg && ack_valid) begin
                mdr_reg <= mem_rdata;
            end
            if (state_reg == ST_FETCH && ack_valid) begin
                mbr_reg <= mem_rdata[7:0];
            end
        end
    end

    assign mem_we    = (state_reg == ST_DATA) && pend_wr_reg;
    assign mem_byte  = (state_reg == ST_FETCH);
    // MAR holds a word address; PC is already a byte address.
    assign mem_addr  = (state_reg == ST_FETCH) ? pc_reg : {mar_reg[DATA_W-3:0], 2'b00};
    assign mem_wdata = mem_we ? mdr_reg : '0;

    assign mar     = mar_reg;
    assign mdr     = mdr_reg;
    assign pc      = pc_reg;
    assign mbr     = mbr_reg;
    assign stall   = stall_reg;
    assign mem_err = err_reg;

endmodule : memory_interface_unit

// File: tb/tb_memory_interface_unit.sv
// ----------------------------------------------------------------------------
// tb_memory_interface_unit
//   Table of directed transactions followed by random transactions. A
//   transaction-level model (register values, sticky error) predicts the
//   architectural state after each transaction and the address/data seen on
//   the memory port during each cycle. The bench plays the memory, acking
//   after a chosen delay or never (timeout).
// ----------------------------------------------------------------------------
module tb_memory_interface_unit;
    import mem_if_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SEL_W   = 9;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 99;

    logic              clock = 1'b0;
    logic              reset;
    logic [SEL_W-1:0]  c_select;
    logic [DATA_W-1:0] c_data;
    logic [2:0]        mem_op;
    logic [DATA_W-1:0] mar, mdr, pc;
    logic [7:0]        mbr;
    logic              stall, mem_err, mem_req, mem_we, mem_byte;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    memory_interface_unit #(
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .SEL_MAR (0),
        .SEL_MDR (1),
        .SEL_PC  (2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .c_select  (c_select),
        .c_data    (c_data),
        .mem_op    (mem_op),
        .mar       (mar),
        .mdr       (mdr),
        .pc        (pc),
        .mbr       (mbr),
        .stall     (stall),
        .mem_err   (mem_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;

    // reference model state
    logic [31:0] m_mar, m_mdr, m_pc;
    logic [7:0]  m_mbr;
    logic        m_err;

    typedef struct {
        logic [8:0]  sel;
        logic [31:0] cdata;
        logic [2:0]  op;
        int          dly_d;
        int          dly_f;
        logic [31:0] rdata_d;
        logic [31:0] rdata_f;
        logic [31:0] exp_mar;
        logic [31:0] exp_mdr;
        logic [31:0] exp_pc;
        logic [7:0]  exp_mbr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_mar = 0; m_mdr = 0; m_pc = 0; m_mbr = 0; m_err = 0;
    endtask

    // One memory cycle: request held until ack at cycle 'dly' or TIMEOUT cycles.
    // Bus C / mem_op are driven with junk throughout, which must be ignored.
    task automatic run_phase(input bit is_fetch, input bit is_wr, input bit is_rd,
                             input int dly, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        for (int k = 0; k < TIMEOUT; k++) begin
            check("req",   mem_req,  1);
            check("byte",  mem_byte, is_fetch);
            check("we",    mem_we,   is_wr);
            check("stall", stall,    1);
            if (k == 0) begin
                check("addr",  mem_addr,  exp_addr);
                check("wdata", mem_wdata, exp_wdata);
            end
            c_select = '1;
            c_data   = $urandom;
            mem_op   = 3'($urandom_range(0, 7));
            if (k == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                step();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                if (is_fetch) m_mbr = rdata[7:0];
                else if (is_rd) m_mdr = rdata;
                return;
            end
            step();
        end
        m_err = 1'b1;   // timed out, target untouched
    endtask

    task automatic do_txn(input logic [8:0] sel, input logic [31:0] cdata, input logic [2:0] op,
                          input int dly_d, input int dly_f,
                          input logic [31:0] rdata_d, input logic [31:0] rdata_f);
        bit is_wr, is_rd;
        c_select  = sel;
        c_data    = cdata;
        mem_op    = op;
        // a stray ack with nothing in flight must be ignored
        mem_ack   = (op == MEM_NONE) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        if (sel[0]) m_mar = cdata;
        if (sel[1]) m_mdr = cdata;
        if (sel[2]) m_pc  = cdata;
        is_wr = op[1];
        is_rd = op[0] && !op[1];
        if (op[0] && op[1]) m_err = 1'b1;
        step();
        mem_ack = 1'b0;
        if (is_wr || is_rd)
            run_phase(1'b0, is_wr, is_rd, dly_d, rdata_d, {m_mar[29:0], 2'b00}, is_wr ? m_mdr : 32'h0);
        if (op[2])
            run_phase(1'b1, 1'b0, 1'b0, dly_f, rdata_f, m_pc, 32'h0);
        c_select = '0;
        mem_op   = MEM_NONE;
        check("stall_end", stall,   0);
        check("req_end",   mem_req, 0);
        check("mar",       mar,     m_mar);
        check("mdr",       mdr,     m_mdr);
        check("pc",        pc,      m_pc);
        check("mbr",       mbr,     m_mbr);
        check("err",       mem_err, m_err);
        n_txn++;
        $display("txn %0d op=%03b sel=%03h mar=%08h mdr=%08h pc=%08h mbr=%02h err=%0b",
                 n_txn, op, sel, mar, mdr, pc, mbr, mem_err);
    endtask

    initial begin
        logic [2:0] ops[8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b011, 3'b111};

        //        sel     cdata          op         dd      df  rdata_d       rdata_f       mar    mdr           pc     mbr    err
        vecs[0] = '{9'h001, 32'h0000_0010, MEM_RD,    0,      0,  32'hDEADBEEF, 32'h0,        32'h10, 32'hDEADBEEF, 32'h0, 8'h00, 1'b0};
        vecs[1] = '{9'h002, 32'h1234_5678, MEM_WR,    2,      0,  32'hFFFFFFFF, 32'h0,        32'h10, 32'h12345678, 32'h0, 8'h00, 1'b0};
        vecs[2] = '{9'h004, 32'h0000_0005, MEM_NONE,  0,      0,  32'h0,        32'h0,        32'h10, 32'h12345678, 32'h5, 8'h00, 1'b0};
        vecs[3] = '{9'h001, 32'h0000_0002, 3'b101,    1,      0,  32'h11112222, 32'h0000_00AB, 32'h2, 32'h11112222, 32'h5, 8'hAB, 1'b0};
        vecs[4] = '{9'h000, 32'h0,         MEM_RD,    NO_ACK, 0,  32'h0,        32'h0,        32'h2,  32'h11112222, 32'h5, 8'hAB, 1'b1};

        reset = 1'b0; c_select = '0; c_data = '0; mem_op = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_mar",   mar,     0);
        check("rst_stall", stall,   0);
        check("rst_req",   mem_req, 0);
        check("rst_err",   mem_err, 0);
        reset = 1'b1;
        step();

        // directed table
        foreach (vecs[i]) begin
            do_txn(vecs[i].sel, vecs[i].cdata, vecs[i].op, vecs[i].dly_d, vecs[i].dly_f,
                   vecs[i].rdata_d, vecs[i].rdata_f);
            check("tbl_mar", mar,     vecs[i].exp_mar);
            check("tbl_mdr", mdr,     vecs[i].exp_mdr);
            check("tbl_pc",  pc,      vecs[i].exp_pc);
            check("tbl_mbr", mbr,     vecs[i].exp_mbr);
            check("tbl_err", mem_err, vecs[i].exp_err);
        end

        // asynchronous reset in the middle of a read cycle
        c_select = 9'h001; c_data = 32'h77; mem_op = MEM_RD;
        step();
        c_select = '0; mem_op = MEM_NONE;
        step();
        check("pre_rst_req", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_mar",   mar,       0);
        check("arst_mdr",   mdr,       0);
        check("arst_pc",    pc,        0);
        check("arst_mbr",   mbr,       0);
        check("arst_stall", stall,     0);
        check("arst_err",   mem_err,   0);
        check("arst_req",   mem_req,   0);
        check("arst_we",    mem_we,    0);
        check("arst_byte",  mem_byte,  0);
        check("arst_wdata", mem_wdata, 0);
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_req", mem_req, 0);
        end

        // random transactions against the model
        for (int t = 0; t < 150; t++) begin
            logic [2:0] op;
            int dd, df;
            op = ops[$urandom_range(0, 7)];
            dd = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 4));
            df = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 4));
            do_txn(9'($urandom), $urandom, op, dd, df, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_memory_interface_unit
